// File: rtl/lsu_align_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align_pkg
// Brief   : Shared types, beat geometry and beat-count helper for the
//           misaligned multi-beat LSU sequencer.
// Revision: 1.0  initial release
// ============================================================================
package lsu_align_pkg;

   // Beat width and largest access size; every derived width below follows them
   localparam int LLEN       = 64;
   localparam int MAXBYTES   = 16;
   localparam int WB         = LLEN / 8;
   localparam int NBEATS_MAX = MAXBYTES / WB + 1;
   localparam int OFFW       = $clog2(WB);
   localparam int KW         = $clog2(NBEATS_MAX + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } statetype;

   // Number of word-aligned beats touched by an access of 2^size_log2 bytes at offset off
   function automatic logic [KW-1:0] beat_count(input logic [OFFW-1:0] off,
                                                input logic [2:0]      size_log2);
      int unsigned total;
      total = int'(off) + (32'd1 << size_log2);
      return KW'((total + WB - 1) / WB);
   endfunction

endpackage
`default_nettype wire

// File: rtl/align_bytemask.sv
`default_nettype none
// ============================================================================
// Module  : align_bytemask
// Brief   : Byte-enable mask of beat k for an access covering bytes
//           [o, o + 2^size) of the beat-aligned window.
// Revision: 1.0  initial release
// ============================================================================
module align_bytemask
   import lsu_align_pkg::*;
(
   input  logic [OFFW-1:0] o,
   input  logic [2:0]      size,
   input  logic [KW-1:0]   k,
   output logic [WB-1:0]   mask
);

   // Wide enough for the largest size code (128 bytes) plus offset and beat base
   localparam int AW = OFFW + 9;

   logic [AW-1:0] w_lo;
   logic [AW-1:0] w_hi;
   logic [AW-1:0] w_beat_base;

   // Access byte range and the first byte index of beat k
   assign w_lo        = AW'(o);
   assign w_hi        = AW'(o) + (AW'(1) << size);
   assign w_beat_base = AW'(k) << OFFW;

   // A byte lane is active when its absolute index falls inside the access range
   generate
      for (genvar j = 0; j < WB; j++) begin : g_byte
         logic [AW-1:0] w_idx;
         assign w_idx   = w_beat_base + AW'(j);
         assign mask[j] = (w_idx >= w_lo) && (w_idx < w_hi);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/lsu_multibeat_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_multibeat_align
// Brief   : Splits one load/store of up to MAXBYTES bytes at any byte address
//           into word-aligned beats, merges load beats into a right-justified
//           result and rotates store data into per-beat lanes.
//           Optional macro LSU_PAGECROSS_FAULT_EN: page-crossing accesses are
//           answered with RspErr and no beats.
// Revision: 1.0  initial release
// ============================================================================
module lsu_multibeat_align
   import lsu_align_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int PAGEBYTES = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  StallM,
   input  logic                  FlushM,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic [XLEN-1:0]       ReqAdr,
   input  logic [2:0]            ReqSizeLog2,
   input  logic                  ReqWrite,
   input  logic [MAXBYTES*8-1:0] ReqWriteData,
   output logic                  BeatValid,
   output logic [XLEN-1:0]       BeatAdr,
   output logic [WB-1:0]         BeatByteMask,
   output logic [LLEN-1:0]       BeatWriteData,
   output logic                  BeatWrite,
   input  logic                  BeatAck,
   input  logic [LLEN-1:0]       BeatReadData,
   output logic                  RspValid,
   output logic [MAXBYTES*8-1:0] RspReadData,
   output logic                  RspErr,
   output logic                  SpillStallM
);

   localparam int BUFBITS = NBEATS_MAX * LLEN;
   localparam int RSPBITS = MAXBYTES * 8;
   localparam int PGW     = $clog2(PAGEBYTES);
   localparam int PNW     = XLEN - PGW;
`ifdef LSU_PAGECROSS_FAULT_EN
   localparam bit PAGE_FAULT_EN = 1'b1;
`else
   localparam bit PAGE_FAULT_EN = 1'b0;
`endif

   statetype           r_state;
   logic [XLEN-1:0]    r_base;
   logic [OFFW-1:0]    r_off;
   logic [2:0]         r_size;
   logic               r_write;
   logic               r_err;
   logic [KW-1:0]      r_n;
   logic [KW-1:0]      r_k;
   logic [BUFBITS-1:0] r_buf;

   logic [8:0]         w_req_nbytes;
   logic [8:0]         w_rsp_nbytes;
   logic [PNW-1:0]     w_first_page;
   logic [PNW-1:0]     w_last_page;
   logic               w_req_err;
   logic [WB-1:0]      w_mask;
   logic [RSPBITS-1:0] w_rsp_data;

   // Size legality and page-crossing test of the incoming request
   assign w_req_nbytes = 9'd1 << ReqSizeLog2;
   assign w_first_page = ReqAdr[XLEN-1:PGW];
   assign w_last_page  = PNW'((ReqAdr + XLEN'(w_req_nbytes) - XLEN'(1)) >> PGW);
   assign w_req_err    = (w_req_nbytes > 9'(MAXBYTES)) ||
                         (PAGE_FAULT_EN && (w_first_page != w_last_page));

   align_bytemask u_mask (
      .o    (r_off),
      .size (r_size),
      .k    (r_k),
      .mask (w_mask)
   );

   // Request capture, beat sequencing and response hold; flush and reset abandon the access
   always_ff @(posedge clk) begin
      if (reset || FlushM) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_off   <= '0;
         r_size  <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_n     <= '0;
         r_k     <= '0;
         r_buf   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ReqValid) begin
                  r_base  <= {ReqAdr[XLEN-1:OFFW], OFFW'(0)};
                  r_off   <= ReqAdr[OFFW-1:0];
                  r_size  <= ReqSizeLog2;
                  r_write <= ReqWrite;
                  r_err   <= w_req_err;
                  r_n     <= beat_count(ReqAdr[OFFW-1:0], ReqSizeLog2);
                  r_k     <= '0;
                  // Store data is pre-rotated so beat k simply reads slot k
                  r_buf   <= BUFBITS'(ReqWriteData) << {ReqAdr[OFFW-1:0], 3'b000};
                  r_state <= w_req_err ? RESP : BEAT;
               end
            end
            BEAT: begin
               if (BeatAck) begin
                  r_buf[r_k*LLEN +: LLEN] <= BeatReadData;
                  if (r_k == r_n - KW'(1)) begin
                     r_state <= RESP;
                  end else begin
                     r_k <= r_k + KW'(1);
                  end
               end
            end
            RESP: begin
               if (!StallM) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_rsp_nbytes = 9'd1 << r_size;

   // Right-justify the merged beats and clear bytes beyond the access size
   always_comb begin
      w_rsp_data = RSPBITS'(r_buf >> {r_off, 3'b000});
      for (int i = 0; i < MAXBYTES; i++) begin
         if (9'(i) >= w_rsp_nbytes) begin
            w_rsp_data[8*i +: 8] = 8'h00;
         end
      end
   end

   // Outputs decode the state register; data outputs are zero outside their phase
   assign ReqReady      = (r_state == IDLE);
   assign BeatValid     = (r_state == BEAT);
   assign BeatAdr       = BeatValid ? (r_base + (XLEN'(r_k) << OFFW)) : '0;
   assign BeatByteMask  = BeatValid ? w_mask : '0;
   assign BeatWrite     = BeatValid && r_write;
   assign BeatWriteData = BeatWrite ? r_buf[r_k*LLEN +: LLEN] : '0;
   assign RspValid      = (r_state == RESP);
   assign RspErr        = RspValid && r_err;
   assign RspReadData   = (RspValid && !r_write && !r_err) ? w_rsp_data : '0;
   assign SpillStallM   = BeatValid || (RspValid && StallM);

endmodule
`default_nettype wire

// File: tb/tb_lsu_multibeat_align.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_multibeat_align
// Brief   : Directed bench for lsu_multibeat_align with a byte-level model of
//           beat addresses, masks, store lanes and merged load results.
// Revision: 1.0  initial release
// ============================================================================
module tb_lsu_multibeat_align;

   logic         clk = 1'b0;
   logic         reset, StallM, FlushM, ReqValid, ReqReady, ReqWrite;
   logic [63:0]  ReqAdr;
   logic [2:0]   ReqSizeLog2;
   logic [127:0] ReqWriteData;
   logic         BeatValid, BeatWrite, BeatAck;
   logic [63:0]  BeatAdr, BeatWriteData, BeatReadData;
   logic [7:0]   BeatByteMask;
   logic         RspValid, RspErr, SpillStallM;
   logic [127:0] RspReadData;

   lsu_multibeat_align dut (
      .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAdr(ReqAdr),
      .ReqSizeLog2(ReqSizeLog2), .ReqWrite(ReqWrite), .ReqWriteData(ReqWriteData),
      .BeatValid(BeatValid), .BeatAdr(BeatAdr), .BeatByteMask(BeatByteMask),
      .BeatWriteData(BeatWriteData), .BeatWrite(BeatWrite), .BeatAck(BeatAck),
      .BeatReadData(BeatReadData), .RspValid(RspValid), .RspReadData(RspReadData),
      .RspErr(RspErr), .SpillStallM(SpillStallM)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Current access as seen by the model
   logic [63:0]  m_adr;
   logic [2:0]   m_size;
   logic         m_write;
   logic [127:0] m_wdata;
   logic [63:0]  m_rd [0:3];
   bit           m_active = 1'b0;
   bit           m_rsp_allowed = 1'b1;
   int           cur_k = 0;

   // Observed values kept for the hand-computed literal checks
   logic [63:0]  seen_adr  [0:3];
   logic [7:0]   seen_mask [0:3];
   logic [63:0]  seen_wd   [0:3];
   logic [127:0] last_rsp;
   logic         last_err;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic int m_nb();
      return 1 << m_size;
   endfunction

   function automatic int m_off();
      return int'(m_adr[2:0]);
   endfunction

   function automatic bit m_err();
      bit e;
      logic [63:0] last;
      e = (m_nb() > 16);
      last = m_adr + 64'(m_nb()) - 64'd1;
`ifdef LSU_PAGECROSS_FAULT_EN
      if ((m_adr >> 12) != (last >> 12)) e = 1'b1;
`else
      if (last == 64'd0 && m_adr == 64'd0) e = e;
`endif
      return e;
   endfunction

   function automatic int m_nbeats();
      if (m_err()) return 0;
      return (m_off() + m_nb() + 7) / 8;
   endfunction

   function automatic logic [63:0] m_beat_adr(input int k);
      return {m_adr[63:3], 3'b000} + 64'(8 * k);
   endfunction

   function automatic logic [7:0] m_beat_mask(input int k);
      logic [7:0] m;
      m = '0;
      for (int j = 0; j < 8; j++)
         m[j] = (8*k + j >= m_off()) && (8*k + j < m_off() + m_nb());
      return m;
   endfunction

   function automatic logic [63:0] lanes(input logic [7:0] m);
      logic [63:0] e;
      for (int j = 0; j < 8; j++) e[8*j +: 8] = {8{m[j]}};
      return e;
   endfunction

   // Store bytes the model expects in the active lanes of beat k
   function automatic logic [63:0] m_beat_wdata(input int k);
      logic [63:0] d;
      logic [7:0]  mk;
      int g;
      d  = '0;
      mk = m_beat_mask(k);
      for (int j = 0; j < 8; j++) begin
         if (mk[j]) begin
            g = 8*k + j - m_off();
            d[8*j +: 8] = m_wdata[8*g +: 8];
         end
      end
      return d;
   endfunction

   // Load result: byte i is the (offset+i)-th byte of the concatenated beats
   function automatic logic [127:0] m_rsp();
      logic [127:0] r;
      int g;
      r = '0;
      if (!m_write) begin
         for (int i = 0; i < m_nb() && i < 16; i++) begin
            g = m_off() + i;
            r[8*i +: 8] = m_rd[g/8][8*(g%8) +: 8];
         end
      end
      return r;
   endfunction

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (m_active) begin
         chk("spill", SpillStallM, BeatValid | (RspValid & StallM));
         if (!m_rsp_allowed) chk("no_rsp_after_flush", RspValid, 1'b0);
         if (BeatValid) begin
            chk("beat_adr", BeatAdr, m_beat_adr(cur_k));
            chk("beat_mask", BeatByteMask, m_beat_mask(cur_k));
            chk("beat_write", BeatWrite, m_write);
            if (m_write)
               chk("beat_wdata", BeatWriteData & lanes(m_beat_mask(cur_k)), m_beat_wdata(cur_k));
            if (cur_k < 4) begin
               seen_adr[cur_k]  = BeatAdr;
               seen_mask[cur_k] = BeatByteMask;
               seen_wd[cur_k]   = BeatWriteData;
            end
         end
         if (RspValid && m_rsp_allowed) begin
            chk("rsp_err", RspErr, m_err());
            if (!m_err()) chk("rsp_data", RspReadData, m_rsp());
            last_rsp = RspReadData;
            last_err = RspErr;
         end
      end
   end

   // Issue one access, answer its beats, optionally withhold beat 1, stall the response or flush
   task automatic run(input logic [63:0] adr, input logic [2:0] sz, input logic wr,
                      input logic [127:0] wd, input int wait1, input int stall,
                      input int flush_k, output int lat, output int rsp_cyc);
      int  waitcnt, stallcnt, cyc;
      bit  done, flushed, ack;
      m_adr = adr; m_size = sz; m_write = wr; m_wdata = wd;
      m_rsp_allowed = (flush_k < 0);
      cur_k = 0; lat = -1; rsp_cyc = 0; waitcnt = 0; stallcnt = 0;
      done = 0; flushed = 0;
      for (int i = 0; i < 4; i++) begin
         seen_adr[i] = 'x; seen_mask[i] = 'x; seen_wd[i] = 'x;
      end
      last_rsp = 'x; last_err = 1'bx;
      @(posedge clk); #1;
      ReqValid = 1'b1; ReqAdr = adr; ReqSizeLog2 = sz; ReqWrite = wr; ReqWriteData = wd;
      m_active = 1'b1;
      @(posedge clk); #1;
      ReqValid = 1'b0;
      cyc = 1;
      while (!done && cyc < 60) begin
         ack = 0;
         if (BeatValid) begin
            if (cur_k == flush_k) begin
               FlushM = 1'b1; BeatAck = 1'b1; BeatReadData = m_rd[cur_k]; flushed = 1;
            end else if (cur_k == 1 && waitcnt < wait1) begin
               waitcnt++;
            end else begin
               BeatAck = 1'b1; BeatReadData = m_rd[cur_k & 3]; ack = 1;
            end
         end
         if (RspValid) begin
            if (lat < 0) lat = cyc;
            rsp_cyc++;
            StallM = (stallcnt < stall);
            stallcnt++;
            if (!StallM) done = 1;
         end
         @(posedge clk); #1;
         if (ack) cur_k++;
         BeatAck = 1'b0; FlushM = 1'b0; StallM = 1'b0;
         cyc++;
         if (flushed) done = 1;
      end
      if (!done) chk("timeout", 1'b0, 1'b1);
   endtask

   int lat, rc;

   initial begin
      #100000;
      $display("FAIL watchdog no completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; StallM = 1'b0; FlushM = 1'b0; ReqValid = 1'b0; ReqAdr = '0;
      ReqSizeLog2 = '0; ReqWrite = 1'b0; ReqWriteData = '0; BeatAck = 1'b0; BeatReadData = '0;
      for (int i = 0; i < 4; i++) m_rd[i] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_ready", ReqReady, 1'b1);
      chk("reset_beatvalid", BeatValid, 1'b0);
      chk("reset_beatadr", BeatAdr, 64'd0);
      chk("reset_mask", BeatByteMask, 8'd0);
      chk("reset_rspvalid", RspValid, 1'b0);
      chk("reset_rsperr", RspErr, 1'b0);
      chk("reset_rspdata", RspReadData, 128'd0);
      chk("reset_spill", SpillStallM, 1'b0);

      // Aligned 8-byte load
      m_rd[0] = 64'hDEADBEEF_01234567;
      run(64'h1000, 3'd3, 1'b0, '0, 0, 0, -1, lat, rc);
      chk("t1_beats", cur_k, 1);
      chk("t1_lat", lat, 2);
      chk("t1_adr", seen_adr[0], 64'h1000);
      chk("t1_mask", seen_mask[0], 8'hFF);
      chk("t1_rsp", last_rsp, 128'hDEADBEEF_01234567);

      // 4-byte load spilling into the next word
      m_rd[0] = 64'h1122_3344_5566_7788; m_rd[1] = 64'h99AA_BBCC_DDEE_FF00;
      run(64'h1006, 3'd2, 1'b0, '0, 0, 0, -1, lat, rc);
      chk("t2_beats", cur_k, 2);
      chk("t2_lat", lat, 3);
      chk("t2_adr1", seen_adr[1], 64'h1008);
      chk("t2_mask0", seen_mask[0], 8'hC0);
      chk("t2_mask1", seen_mask[1], 8'h03);
      chk("t2_rsp", last_rsp, 128'h0000_0000_FF00_1122);

      // 16-byte store over three beats, beat 1 ack withheld, response stalled
      run(64'h2003, 3'd4, 1'b1, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 3, 2, -1, lat, rc);
      chk("t3_beats", cur_k, 3);
      chk("t3_lat", lat, 7);
      chk("t3_rsp_cycles", rc, 3);
      chk("t3_adr2", seen_adr[2], 64'h2010);
      chk("t3_mask0", seen_mask[0], 8'hF8);
      chk("t3_mask1", seen_mask[1], 8'hFF);
      chk("t3_mask2", seen_mask[2], 8'h07);
      chk("t3_wd0", seen_wd[0][63:24], 40'h04_0302_0100);
      chk("t3_wd1", seen_wd[1], 64'h0C0B0A09_08070605);
      chk("t3_rsp", last_rsp, 128'd0);

      // Flush during beat 1, then a fresh request
      m_rd[0] = 64'h0101_0101_0101_0101; m_rd[1] = 64'h0202_0202_0202_0202;
      run(64'h3004, 3'd4, 1'b0, '0, 0, 0, 1, lat, rc);
      chk("t4_ready_after_flush", ReqReady, 1'b1);
      chk("t4_idle_after_flush", BeatValid, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      m_rd[0] = 64'hA1A2A3A4_A5A6A7A8; m_rd[1] = 64'hB1B2B3B4_B5B6B7B8;
      run(64'h10FF, 3'd1, 1'b0, '0, 0, 0, -1, lat, rc);
      chk("t5_beats", cur_k, 2);
      chk("t5_mask0", seen_mask[0], 8'h80);
      chk("t5_mask1", seen_mask[1], 8'h01);
      chk("t5_rsp", last_rsp, 128'hB8A1);

      // Illegal size: error response, no beats
      run(64'h5000, 3'd5, 1'b0, '0, 0, 0, -1, lat, rc);
      chk("t6_beats", cur_k, 0);
      chk("t6_lat", lat, 1);
      chk("t6_err", last_err, 1'b1);

      // Page-crossing 8-byte load
      m_rd[0] = 64'h0011_2233_4455_6677; m_rd[1] = 64'h8899_AABB_CCDD_EEFF;
      run(64'h1FFC, 3'd3, 1'b0, '0, 0, 0, -1, lat, rc);
`ifdef LSU_PAGECROSS_FAULT_EN
      chk("t7_beats", cur_k, 0);
      chk("t7_err", last_err, 1'b1);
`else
      chk("t7_beats", cur_k, 2);
      chk("t7_adr0", seen_adr[0], 64'h1FF8);
      chk("t7_adr1", seen_adr[1], 64'h2000);
      chk("t7_rsp", last_rsp, 128'hCCDD_EEFF_0011_2233);
`endif

      // Single byte at the last lane
      m_rd[0] = 64'h5500_0000_0000_0000;
      run(64'h1007, 3'd0, 1'b0, '0, 0, 0, -1, lat, rc);
      chk("t8_beats", cur_k, 1);
      chk("t8_mask", seen_mask[0], 8'h80);
      chk("t8_rsp", last_rsp, 128'h55);

      // Address wrap at the top of the address space
      m_rd[0] = 64'h1111_2222_3333_4444; m_rd[1] = 64'h5555_6666_7777_8888;
      run(64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 1'b0, '0, 0, 0, -1, lat, rc);
`ifdef LSU_PAGECROSS_FAULT_EN
      chk("t9_err", last_err, 1'b1);
`else
      chk("t9_adr1", seen_adr[1], 64'h0);
      chk("t9_rsp", last_rsp, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
`endif

      // Narrow store in the middle of a word
      run(64'h4005, 3'd1, 1'b1, 128'hBEEF, 0, 0, -1, lat, rc);
      chk("t10_mask", seen_mask[0], 8'h60);
      chk("t10_wd", seen_wd[0][55:40], 16'hBEEF);

      m_active = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_multibeat_align.md
Name: lsu_multibeat_align

Overview:
- Next-generation LSU misaligned-access sequencer.
- Splits one load/store of up to MAXBYTES bytes, at any byte address, into 1..NBEATS_MAX word-aligned LLEN-bit beats toward the D$/bus.
- For loads, merges returned beats into one right-justified result; for stores, rotates data and generates per-beat byte masks.
- Sits between the M-stage address/data path and the cache request port; handles accesses wider than one word, not only the two-word spill case.

Parameters:
- XLEN, 64, address width
- LLEN, 64, beat data width in bits; WB = LLEN/8 bytes per beat
- MAXBYTES, 16, largest access in bytes (power of two, >= WB)
- PAGEBYTES, 4096, page size, used only by the optional feature
- NBEATS_MAX, MAXBYTES/WB+1, derived; maximum beats per access

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- StallM  in  1  pipeline stall; holds the response
- FlushM  in  1  abort the current access
- ReqValid  in  1  access request
- ReqReady  out  1  sequencer can accept a request
- ReqAdr  in  XLEN  byte address
- ReqSizeLog2  in  3  access size is 2^ReqSizeLog2 bytes
- ReqWrite  in  1  1 = store
- ReqWriteData  in  MAXBYTES*8  store data, right-justified
- BeatValid  out  1  beat request to cache
- BeatAdr  out  XLEN  word-aligned beat address
- BeatByteMask  out  WB  active bytes in this beat
- BeatWriteData  out  LLEN  store data for this beat
- BeatWrite  out  1  beat is a store
- BeatAck  in  1  cache completes the beat this cycle
- BeatReadData  in  LLEN  load data, valid with BeatAck
- RspValid  out  1  access complete
- RspReadData  out  MAXBYTES*8  merged, right-justified load data; upper bytes zero
- RspErr  out  1  illegal size (or page cross, with the optional feature)
- SpillStallM  out  1  busy: BeatValid | (RspValid & StallM)

Behaviour:
- Reset: state IDLE; all outputs 0 except ReqReady=1.
- States and transitions:
  - IDLE: ReqReady=1. On ReqValid, latch the request, compute offset o=ReqAdr[log2(WB)-1:0], base=ReqAdr with those bits cleared, and n=ceil((o+2^size)/WB).
    - If 2^size > MAXBYTES, go to RESP with RspErr=1 and issue no beats.
    - Otherwise go to BEAT with k=0.
  - BEAT: BeatValid=1 and BeatAdr=base+k*WB (mod 2^XLEN, wraps).
    - BeatByteMask = bytes of [o, o+2^size) within [k*WB, (k+1)*WB).
    - BeatWriteData = slice k of (ReqWriteData << 8*o) in an NBEATS_MAX*WB-byte buffer.
    - All Beat* outputs are held stable until BeatAck.
    - On BeatAck, store BeatReadData into buffer slot k and increment k. If k==n-1, go to RESP.
  - RESP: RspValid=1. RspReadData = (buffer >> 8*o) truncated to MAXBYTES, with bytes at index >= 2^size zeroed (no sign extension).
    - Stay in RESP while StallM=1; go to IDLE when StallM=0.
- Latency: request accepted at cycle t; first BeatValid at t+1; with zero-wait acks, RspValid at t+1+n.
- Stores: RspReadData=0.
- FlushM in any state: IDLE next cycle, no RspValid, buffer contents discarded, a BeatAck in the same cycle is ignored. FlushM has priority over BeatAck and over ReqValid.
- Reset mid-access behaves exactly as FlushM.
- Bytes 0 access (size 0) always gives n=1.
- ReqValid while not in IDLE is ignored (ReqReady=0).

Optional Feature:
- Macro: LSU_PAGECROSS_FAULT_EN
- Defined: if floor(ReqAdr/PAGEBYTES) != floor((ReqAdr+2^size-1)/PAGEBYTES), go to RESP with RspErr=1 and issue no beats.
- Undefined: page-crossing accesses are sequenced normally.

Decomposition:
- Package lsu_align_pkg holds:
  - statetype enum {IDLE, BEAT, RESP}
  - WB and NBEATS_MAX localparams
  - a beat-count function
- One combinational sub-module, align_bytemask: inputs o, size, k; output WB-bit mask. It is instantiated once and indexed by k.

Test Plan (LLEN=64, MAXBYTES=16):
- Aligned 8-byte load at 0x1000, ack 0xDEADBEEF_01234567 → one beat, BeatAdr=0x1000, mask 0xFF; RspReadData low 64 bits=0xDEADBEEF_01234567, RspValid at t+2.
- 4-byte load at 0x1006 → beats 0x1000 mask 0xC0, then 0x1008 mask 0x03; with w0=0x1122_3344_5566_7788 and w1=0x99AA_BBCC_DDEE_FF00, RspReadData=0x0000_0000_FF00_1122.
- 16-byte store at 0x2003, data 0x0F0E…0100 → three beats at 0x2000/0x2008/0x2010, masks 0xF8/0xFF/0x07; beat0 data[63:24]=0x0403020100.
- BeatAck withheld 3 cycles on beat 1 → BeatAdr, mask and data unchanged throughout; RspValid one cycle after the final ack; StallM=1 holds RspValid.
- FlushM during beat 1 → next cycle IDLE, ReqReady=1, no RspValid ever; a new request proceeds normally.
- 8-byte load at 0x1FFC with PAGEBYTES=4096:
  - macro defined → RspErr=1, no BeatValid.
  - macro undefined → beats 0x1FF8 and 0x2000.
